timer_irq_ctrl: RTL and testbench
=================================

# timer_irq_ctrl

Interrupt controller directly downstream of the 8-bit timer. It consumes the timer's overflow and underflow status levels (TSR bits 0 and 1) and latches a rising edge on each into a pending bit. Per-source enables and a global enable gate the pending bits, and the block drives one interrupt line to the CPU in level or pulse mode. It is an APB slave on the same bus as the timer, with zero wait states.

## Interface
- `NSRC`, default 2: number of interrupt sources. Bit 0 = overflow, bit 1 = underflow.
- `pclk` in 1: sole clock; all state updates on the rising edge.
- `preset` in 1: synchronous, active-high reset.
- `psel` in 1: APB select.
- `penable` in 1: APB access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in 8: register address.
- `pwdata` in 8: write data.
- `prdata` out 8: read data; valid in the access phase, 0 otherwise.
- `pready` out 1: tied high (zero wait states).
- `pslverr` out 1: high in the access phase when `paddr` > 0x04.
- `tmr_src` in NSRC: timer status levels, from TSR[1:0].
- `irq` out 1: registered interrupt request to the CPU.

## Operation
Register map:
- 0x00 IER [1:0], RW: per-source enable.
- 0x01 IPR [1:0], read returns pending; write-1-to-clear.
- 0x02 ICR, RW: bit0 GIE (global enable); bit1 MODE (0 = level, 1 = pulse).
- 0x03 MISS [7:0], RO: saturating count of lost events; any write clears it to 0.
- 0x04 STAT, RO: bit0 = `irq`; bits [2:1] = `active` = IPR & IER.
- Unused bits read 0.

Write and read qualification:
- A write commits when `psel & penable & pwrite`.
- Writes to 0x03 clear MISS. Writes to 0x04 or to an invalid address are ignored.
- Invalid addresses read 0 and raise `pslverr`.

Event detection:
- `src_q` samples `tmr_src` every cycle.
- `edge` = `tmr_src & ~src_q`.
- For each bit with `edge` = 1:
  - If the pending bit is 0, it is set.
  - If the pending bit is already 1, MISS increments, saturating at 0xFF.
- Two simultaneous edges on already-pending bits add 2, still saturating.

IRQ generation:
- `act` = GIE & |(IPR & IER).
- Level mode: `irq` <= `act`.
- Pulse mode: `irq` <= `act & ~act_q` (one cycle per 0→1 transition of `act`); `act_q` registers `act`.
- Changing MODE while `act` = 1 produces no pulse. `act_q` tracks `act` in both modes.

Simultaneous events and priority:
- Edge set and W1C on the same bit in the same cycle: set wins (pending stays 1, MISS unchanged).
- MISS increment and MISS clear in the same cycle: clear wins (MISS = 0).
- IER, GIE and MODE have no effect on pending capture. Events are always latched.

## Timing
Reset (`preset` = 1 at a `pclk` edge):
- IER, IPR, ICR, MISS, `src_q`, `act_q` and `irq` all become 0.
- `pready` = 1. `prdata` = 0 and `pslverr` = 0 outside the access phase.
- Because `src_q` resets to 0, a source that is high when reset deasserts registers one event on the first edge after reset.
- Reset mid-transfer aborts the write; no register changes.

Latency:
- `tmr_src` high before edge k → IPR bit = 1 after edge k → `irq` = 1 after edge k+1. Total: 2 cycles.
- W1C clearing the last active bit at edge k → `irq` low after edge k+1.
- Register writes are visible to a read in the next APB transfer.

APB:
- Setup cycle, then access cycle. Each transfer is 2 `pclk` cycles.
- `prdata` is combinational from the registers during the access phase.

## Test plan
- Reset, then read 0x00–0x04 → all 0x00; `irq` = 0; `pslverr` = 0. Read 0x05 → `prdata` = 0x00, `pslverr` = 1.
- IER = 0x01, ICR = 0x01, drive `tmr_src` = 2'b01 → IPR reads 0x01; `irq` rises 2 cycles after the source; STAT = 0x03. Write IPR = 0x01 → `irq` = 0 one cycle later; IPR = 0x00.
- IER = 0x00, pulse `tmr_src[1]` → IPR = 0x02 and `irq` stays 0. Then write IER = 0x02 → `irq` = 1 one cycle after the write commits.
- ICR = 0x03 (pulse mode), IER = 0x03, edge on source 0 → `irq` high for exactly 1 cycle. Edge on source 1 while source 0 is still pending → no second pulse.
- With IPR[0] = 1, apply 300 rising edges on `tmr_src[0]` → MISS = 0xFF. Write 0x03 → MISS = 0x00. An edge coinciding with W1C of IPR[0] → IPR[0] stays 1 and MISS is unchanged.
- Assert `preset` during the access phase of a write to IER = 0x03 → IER = 0x00 afterwards. Hold `tmr_src` = 2'b11 through reset → IPR = 0x03 one cycle after reset deasserts.

Source files
------------

// File: rtl/timer_irq_ctrl_if.sv
// timer_irq_ctrl_if: APB bus bundle (psel/penable/pwrite/paddr/pwdata in, prdata/pready/pslverr out) with master/slave modports
interface timer_irq_ctrl_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  modport master(output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave(input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: timer edge-latching interrupt controller; ports pclk, preset (sync high), apb (slave), tmr_src[NSRC] in, irq out
module timer_irq_ctrl #(
  parameter int NSRC = 2
) (
  input  logic               pclk,
  input  logic               preset,
  timer_irq_ctrl_if.slave    apb,
  input  logic [NSRC-1:0]    tmr_src,
  output logic               irq
);
  logic [NSRC-1:0] ier, ipr, src_q, rise, clr, lost;
  logic            gie, mode, act, act_q, acc, wr;
  logic [7:0]      miss, lost_cnt, rdata;
  logic [8:0]      sum;
  assign acc  = apb.psel & apb.penable;
  assign wr   = acc & apb.pwrite;
  assign clr  = (wr && apb.paddr == 8'h01) ? apb.pwdata[NSRC-1:0] : '0;
  assign rise = tmr_src & ~src_q;
  assign lost = rise & ipr & ~clr;
  assign sum  = {1'b0, miss} + {1'b0, lost_cnt};
  assign act  = gie & |(ipr & ier);
  always_comb begin
    lost_cnt = '0;
    for (int i = 0; i < NSRC; i++) lost_cnt = lost_cnt + 8'(lost[i]);
  end
  assign rdata = apb.paddr == 8'h00 ? 8'({ier}) :
                 apb.paddr == 8'h01 ? 8'({ipr}) :
                 apb.paddr == 8'h02 ? {6'b0, mode, gie} :
                 apb.paddr == 8'h03 ? miss :
                 apb.paddr == 8'h04 ? {{(7-NSRC){1'b0}}, ipr & ier, irq} : 8'h00;
  assign apb.prdata  = acc ? rdata : 8'h00;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = acc & (apb.paddr > 8'h04);
  always_ff @(posedge pclk) begin
    if (preset) begin
      ier   <= '0;
      ipr   <= '0;
      gie   <= 1'b0;
      mode  <= 1'b0;
      miss  <= '0;
      src_q <= '0;
      act_q <= 1'b0;
      irq   <= 1'b0;
    end else begin
      src_q <= tmr_src;
      act_q <= act;
      irq   <= mode ? act & ~act_q : act;
      ipr   <= (ipr & ~clr) | rise;
      miss  <= (wr && apb.paddr == 8'h03) ? 8'h00 : sum[8] ? 8'hff : sum[7:0];
      if (wr && apb.paddr == 8'h00) ier <= apb.pwdata[NSRC-1:0];
      if (wr && apb.paddr == 8'h02) {mode, gie} <= apb.pwdata[1:0];
    end
  end
endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb_timer_irq_ctrl: directed self-checking bench for timer_irq_ctrl
module tb_timer_irq_ctrl;
  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic [1:0] tmr_src = 2'b00;
  logic       irq;
  logic [7:0] rd;
  logic       err;
  int         errors = 0;
  int         checks = 0;
  int         highs;
  timer_irq_ctrl_if bus();
  timer_irq_ctrl #(.NSRC(2)) dut(.pclk(pclk), .preset(preset), .apb(bus.slave), .tmr_src(tmr_src), .irq(irq));
  always #5 pclk = ~pclk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite = 1'b0;
    bus.paddr = 8'h00;
    bus.pwdata = 8'h00;
  endtask
  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge pclk);
    bus.psel = 1'b1;
    bus.pwrite = 1'b1;
    bus.paddr = a;
    bus.pwdata = d;
    @(negedge pclk);
    bus.penable = 1'b1;
    @(negedge pclk);
    idle();
  endtask
  task automatic apb_read(input logic [7:0] a, output logic [7:0] d, output logic e);
    @(negedge pclk);
    bus.psel = 1'b1;
    bus.pwrite = 1'b0;
    bus.paddr = a;
    @(negedge pclk);
    bus.penable = 1'b1;
    #1;
    d = bus.prdata;
    e = bus.pslverr;
    @(negedge pclk);
    idle();
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask
  initial begin
    idle();
    cyc(3);
    preset = 1'b0;
    chk("pready", 8'(bus.pready), 8'h01);
    chk("rst_pslverr", 8'(bus.pslverr), 8'h00);
    chk("rst_prdata_idle", bus.prdata, 8'h00);
    for (int a = 0; a < 5; a++) begin
      apb_read(8'(a), rd, err);
      chk($sformatf("rst_reg%0d", a), rd, 8'h00);
      chk($sformatf("rst_err%0d", a), 8'(err), 8'h00);
    end
    chk("rst_irq", 8'(irq), 8'h00);
    apb_read(8'h05, rd, err);
    chk("bad_rd", rd, 8'h00);
    chk("bad_err", 8'(err), 8'h01);
    // level mode, source 0 latency and W1C
    apb_write(8'h00, 8'h01);
    apb_write(8'h02, 8'h01);
    @(negedge pclk);
    tmr_src = 2'b01;
    @(negedge pclk);
    chk("lat_irq_k", 8'(irq), 8'h00);
    @(negedge pclk);
    chk("lat_irq_k1", 8'(irq), 8'h01);
    apb_read(8'h01, rd, err);
    chk("ipr_src0", rd, 8'h01);
    apb_read(8'h04, rd, err);
    chk("stat_src0", rd, 8'h03);
    apb_write(8'h01, 8'h01);
    chk("w1c_irq_k", 8'(irq), 8'h01);
    @(negedge pclk);
    chk("w1c_irq_k1", 8'(irq), 8'h00);
    apb_read(8'h01, rd, err);
    chk("ipr_cleared", rd, 8'h00);
    tmr_src = 2'b00;
    // disabled source still latches; enabling later raises irq
    apb_write(8'h00, 8'h00);
    @(negedge pclk);
    tmr_src = 2'b10;
    @(negedge pclk);
    tmr_src = 2'b00;
    cyc(2);
    apb_read(8'h01, rd, err);
    chk("ipr_src1", rd, 8'h02);
    chk("irq_masked", 8'(irq), 8'h00);
    apb_write(8'h00, 8'h02);
    chk("ier_irq_k", 8'(irq), 8'h00);
    @(negedge pclk);
    chk("ier_irq_k1", 8'(irq), 8'h01);
    apb_write(8'h01, 8'h02);
    cyc(2);
    chk("irq_clr2", 8'(irq), 8'h00);
    // pulse mode
    apb_write(8'h02, 8'h03);
    apb_write(8'h00, 8'h03);
    @(negedge pclk);
    tmr_src = 2'b01;
    @(negedge pclk);
    chk("pulse_k", 8'(irq), 8'h00);
    @(negedge pclk);
    chk("pulse_k1", 8'(irq), 8'h01);
    @(negedge pclk);
    chk("pulse_k2", 8'(irq), 8'h00);
    tmr_src = 2'b11;
    highs = 0;
    repeat (4) begin
      @(negedge pclk);
      if (irq) highs++;
    end
    chk("no_second_pulse", 8'(highs), 8'h00);
    apb_read(8'h01, rd, err);
    chk("ipr_both", rd, 8'h03);
    apb_read(8'h03, rd, err);
    chk("miss_none", rd, 8'h00);
    // MISS saturation
    tmr_src = 2'b00;
    apb_write(8'h01, 8'h03);
    @(negedge pclk);
    tmr_src = 2'b01;
    @(negedge pclk);
    tmr_src = 2'b00;
    repeat (300) begin
      @(negedge pclk);
      tmr_src = 2'b01;
      @(negedge pclk);
      tmr_src = 2'b00;
    end
    apb_read(8'h03, rd, err);
    chk("miss_sat", rd, 8'hff);
    apb_write(8'h03, 8'h5a);
    apb_read(8'h03, rd, err);
    chk("miss_clr", rd, 8'h00);
    // edge on IPR[0] in the same cycle as its W1C
    @(negedge pclk);
    bus.psel = 1'b1;
    bus.pwrite = 1'b1;
    bus.paddr = 8'h01;
    bus.pwdata = 8'h01;
    @(negedge pclk);
    bus.penable = 1'b1;
    tmr_src = 2'b01;
    @(negedge pclk);
    idle();
    apb_read(8'h01, rd, err);
    chk("set_wins_ipr", rd, 8'h01);
    apb_read(8'h03, rd, err);
    chk("set_wins_miss", rd, 8'h00);
    // reset in the access phase of a write, sources held high through reset
    tmr_src = 2'b00;
    cyc(2);
    @(negedge pclk);
    bus.psel = 1'b1;
    bus.pwrite = 1'b1;
    bus.paddr = 8'h00;
    bus.pwdata = 8'h03;
    @(negedge pclk);
    bus.penable = 1'b1;
    preset = 1'b1;
    tmr_src = 2'b11;
    @(negedge pclk);
    idle();
    preset = 1'b0;
    apb_read(8'h00, rd, err);
    chk("rst_abort_ier", rd, 8'h00);
    apb_read(8'h01, rd, err);
    chk("rst_held_ipr", rd, 8'h03);
    apb_read(8'h02, rd, err);
    chk("rst_icr", rd, 8'h00);
    chk("rst_irq2", 8'(irq), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
